prog_loader: RTL and testbench

//  Program-memory loader and instruction server for the processor core. Accepts a

---
 rtl/prog_loader.sv | 153 +++++++++++++++
 tb/tb_prog_loader.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
// Program-memory loader: clears the instruction store, accepts a byte stream into it,
// then holds the core in reset briefly before serving its fetches.
module prog_loader #(
    parameter int                ADDR_W         = 5,
    parameter int                DATA_W         = 8,
    parameter int                DEPTH          = 32,
    parameter int                RELEASE_CYCLES = 2,
    parameter logic [DATA_W-1:0] NOP_CODE       = 8'h00
) (
    input  logic              clk,
    input  logic              rst_ext,
    input  logic              load_start,
    input  logic              wr_valid,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_last,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] prog_cnt,
    output logic [DATA_W-1:0] instruction_code,
    output logic              cpu_rstn,
    output logic              load_done,
    output logic [ADDR_W:0]   wr_count
);

    localparam int REL_W = (RELEASE_CYCLES > 1) ? $clog2(RELEASE_CYCLES) : 1;
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W:0]   CNT_MAX   = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W + 1)'(1);
    localparam logic [REL_W-1:0]  REL_LAST  = REL_W'(RELEASE_CYCLES - 1);
    localparam logic [REL_W-1:0]  REL_ONE   = REL_W'(1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_LOAD,
        ST_RELEASE,
        ST_RUN
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W:0]     wr_count_q, wr_count_d;
    logic [REL_W-1:0]    rel_q, rel_d;
    logic                wr_ready_q, wr_ready_d;
    logic                cpu_rstn_q, cpu_rstn_d;
    logic                load_done_q, load_done_d;
    logic [DATA_W-1:0]   instr_q, instr_d;

    logic                mem_we;
    logic [ADDR_W-1:0]   mem_waddr;
    logic [DATA_W-1:0]   mem_wdata;
    logic                beat;

    logic [DATA_W-1:0]   mem [DEPTH];

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wr_count_d = wr_count_q;
        rel_d      = rel_q;
        mem_we     = 1'b0;
        mem_waddr  = addr_q;
        mem_wdata  = NOP_CODE;
        beat       = (state_q == ST_LOAD) && wr_valid && wr_ready_q;

        case (state_q)
            ST_IDLE: begin
                if (load_start) begin
                    state_d = ST_CLEAR;
                    addr_d  = '0;
                end
            end
            ST_CLEAR: begin
                mem_we = 1'b1;
                addr_d = addr_q + ADDR_ONE;
                if (addr_q == ADDR_LAST) begin
                    state_d    = ST_LOAD;
                    addr_d     = '0;
                    wr_count_d = '0;
                end
            end
            ST_LOAD: begin
                if (beat) begin
                    mem_we     = 1'b1;
                    mem_wdata  = wr_data;
                    addr_d     = addr_q + ADDR_ONE;
                    wr_count_d = (wr_count_q == CNT_MAX) ? wr_count_q : wr_count_q + CNT_ONE;
                    // The last store slot ends the load even without wr_last.
                    if (wr_last || (addr_q == ADDR_LAST)) begin
                        state_d = ST_RELEASE;
                        rel_d   = '0;
                    end
                end
            end
            ST_RELEASE: begin
                if (rel_q == REL_LAST) begin
                    state_d = ST_RUN;
                end else begin
                    rel_d = rel_q + REL_ONE;
                end
            end
            ST_RUN: begin
                if (load_start) begin
                    state_d = ST_CLEAR;
                    addr_d  = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Outputs are registered from the next state so they change on the transition edge.
        wr_ready_d  = (state_d == ST_LOAD);
        cpu_rstn_d  = (state_d == ST_RUN);
        load_done_d = (state_d == ST_RUN);
        instr_d     = (state_q == ST_RUN) ? mem[prog_cnt] : NOP_CODE;
    end

    always_ff @(posedge clk or posedge rst_ext) begin
        if (rst_ext) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            wr_count_q  <= '0;
            rel_q       <= '0;
            wr_ready_q  <= 1'b0;
            cpu_rstn_q  <= 1'b0;
            load_done_q <= 1'b0;
            instr_q     <= NOP_CODE;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wr_count_q  <= wr_count_d;
            rel_q       <= rel_d;
            wr_ready_q  <= wr_ready_d;
            cpu_rstn_q  <= cpu_rstn_d;
            load_done_q <= load_done_d;
            instr_q     <= instr_d;
        end
    end

    // Store contents survive reset; only CLEAR initialises them.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    assign wr_ready         = wr_ready_q;
    assign cpu_rstn         = cpu_rstn_q;
    assign load_done        = load_done_q;
    assign wr_count         = wr_count_q;
    assign instruction_code = instr_q;

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: fixed fetch vectors, hand-written load sequences and
// randomized backpressured loads checked against an array model of the store.
module tb_prog_loader;

    logic       clk = 1'b0;
    logic       rst_ext = 1'b0;
    logic       load_start = 1'b0;
    logic       wr_valid = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       wr_last = 1'b0;
    logic       wr_ready;
    logic [4:0] prog_cnt = 5'd0;
    logic [7:0] instruction_code;
    logic       cpu_rstn;
    logic       load_done;
    logic [5:0] wr_count;

    prog_loader dut (
        .clk              (clk),
        .rst_ext          (rst_ext),
        .load_start       (load_start),
        .wr_valid         (wr_valid),
        .wr_data          (wr_data),
        .wr_last          (wr_last),
        .wr_ready         (wr_ready),
        .prog_cnt         (prog_cnt),
        .instruction_code (instruction_code),
        .cpu_rstn         (cpu_rstn),
        .load_done        (load_done),
        .wr_count         (wr_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: store image plus the progress of the current load.
    logic [7:0] model_mem [32];
    bit         model_loading = 1'b0;
    int         model_addr    = 0;
    int         model_count   = 0;

    typedef struct {
        logic [4:0] pc;
        logic [7:0] exp;
    } fetch_vec_t;
    fetch_vec_t vecs [4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_beat(input logic [7:0] d, input logic l);
        if (model_loading) begin
            model_mem[model_addr] = d;
            model_count++;
            if (l || model_addr == 31) model_loading = 1'b0;
            model_addr++;
        end
    endtask

    // Pulse load_start, then measure how long CLEAR lasts until wr_ready.
    task automatic start_load();
        int cnt;
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        check("start_cpu_rstn_low", cpu_rstn, 0);
        check("start_load_done_low", load_done, 0);
        cnt = 0;
        while (!wr_ready && cnt < 100) begin
            tick();
            cnt++;
            if (cnt == 5) check("clear_instr_nop", instruction_code, 8'h00);
        end
        check("clear_cycles", cnt, 32);
        for (int i = 0; i < 32; i++) model_mem[i] = 8'h00;
        model_loading = 1'b1;
        model_addr    = 0;
        model_count   = 0;
        check("load_wr_count_zero", wr_count, 0);
    endtask

    task automatic send_beat(input logic [7:0] d, input logic l);
        check("beat_ready", wr_ready, model_loading);
        wr_valid = 1'b1;
        wr_data  = d;
        wr_last  = l;
        tick();
        wr_valid = 1'b0;
        wr_last  = 1'b0;
        model_beat(d, l);
    endtask

    task automatic wait_run(input int expect_cycles);
        int cnt;
        cnt = 0;
        while (!cpu_rstn && cnt < 50) begin
            tick();
            cnt++;
        end
        if (expect_cycles >= 0) check("release_cycles", cnt, expect_cycles);
        check("run_cpu_rstn", cpu_rstn, 1);
        check("run_load_done", load_done, 1);
        check("run_wr_ready_low", wr_ready, 0);
    endtask

    task automatic fetch_all();
        for (int a = 0; a < 32; a++) begin
            prog_cnt = 5'(a);
            tick();
            check($sformatf("fetch_%0d", a), instruction_code, model_mem[a]);
        end
    endtask

    initial begin
        int guard;
        logic v;
        logic [7:0] d;

        vecs[0] = '{pc: 5'd0, exp: 8'hA1};
        vecs[1] = '{pc: 5'd1, exp: 8'hB2};
        vecs[2] = '{pc: 5'd2, exp: 8'hC3};
        vecs[3] = '{pc: 5'd3, exp: 8'h00};

        // Reset
        rst_ext = 1'b1;
        tick();
        tick();
        rst_ext = 1'b0;
        check("rst_cpu_rstn", cpu_rstn, 0);
        check("rst_wr_ready", wr_ready, 0);
        check("rst_load_done", load_done, 0);
        check("rst_instr", instruction_code, 8'h00);
        check("rst_wr_count", wr_count, 0);

        // wr_valid in IDLE is ignored
        send_beat(8'hEE, 1'b1);
        check("idle_wr_count", wr_count, 0);

        // Three-byte load
        start_load();
        send_beat(8'hA1, 1'b0);
        send_beat(8'hB2, 1'b0);
        send_beat(8'hC3, 1'b1);
        check("last_wr_ready_low", wr_ready, 0);
        check("last_cpu_rstn_low", cpu_rstn, 0);
        check("last_wr_count", wr_count, 3);
        wait_run(2);

        // Fetch vectors
        for (int i = 0; i < 4; i++) begin
            prog_cnt = vecs[i].pc;
            tick();
            check($sformatf("vec_fetch_%0d", i), instruction_code, vecs[i].exp);
        end

        // Full load: 32 beats, then a 33rd that must be ignored
        start_load();
        for (int i = 0; i < 32; i++) send_beat(8'($urandom), 1'b0);
        check("full_wr_ready_low", wr_ready, 0);
        check("full_wr_count", wr_count, 32);
        send_beat(8'h5A, 1'b1);
        wait_run(-1);
        check("full_wr_count_run", wr_count, 32);
        prog_cnt = 5'd31;
        tick();
        check("full_mem31", instruction_code, model_mem[31]);
        fetch_all();

        // Backpressured random load of 10 bytes
        start_load();
        guard = 0;
        while (model_loading && guard < 400) begin
            v = 1'($urandom_range(0, 1));
            d = 8'($urandom);
            wr_valid = v;
            wr_data  = d;
            wr_last  = (model_count == 9);
            tick();
            if (v) model_beat(d, model_count == 9);
            guard++;
        end
        wr_valid = 1'b0;
        wr_last  = 1'b0;
        check("rand_load_finished", model_loading, 0);
        check("rand_wr_count", wr_count, 10);
        wait_run(-1);
        for (int i = 0; i < 40; i++) begin
            int a;
            a = $urandom_range(0, 31);
            prog_cnt = 5'(a);
            tick();
            check($sformatf("rand_fetch_%0d", a), instruction_code, model_mem[a]);
        end

        // Reload from RUN: old program must read NOP after CLEAR
        start_load();
        send_beat(8'h3C, 1'b1);
        wait_run(2);
        fetch_all();

        // Reset in the middle of a load
        start_load();
        for (int i = 0; i < 5; i++) send_beat(8'h10 + 8'(i), 1'b0);
        check("mid_wr_count", wr_count, 5);
        rst_ext = 1'b1;
        #1;
        check("midrst_cpu_rstn", cpu_rstn, 0);
        check("midrst_wr_ready", wr_ready, 0);
        check("midrst_wr_count", wr_count, 0);
        tick();
        rst_ext = 1'b0;
        model_loading = 1'b0;
        send_beat(8'h99, 1'b0);
        start_load();
        send_beat(8'h7E, 1'b1);
        wait_run(2);
        for (int a = 0; a < 5; a++) begin
            prog_cnt = 5'(a);
            tick();
            check($sformatf("reload_fetch_%0d", a), instruction_code, (a == 0) ? 8'h7E : 8'h00);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
